// File: rtl/light_dance_seq_if.sv
// Register-file side bundle of the light sequencer: seed/mode/rate controls in,
// lamp pattern, step pulse and bounce direction out.
interface light_dance_seq_if #(
    parameter int WIDTH = 8,
    parameter int DIV_W = 4
);
    logic             load;
    logic [WIDTH-1:0] pdata;
    logic             din;
    logic [2:0]       mode;
    logic [DIV_W-1:0] div;
    logic             run;
    logic [WIDTH-1:0] qdata;
    logic             step;
    logic             dir;

    modport master (
        output load, pdata, din, mode, div, run,
        input  qdata, step, dir
    );

    modport slave (
        input  load, pdata, din, mode, div, run,
        output qdata, step, dir
    );
endinterface

// File: rtl/light_dance_seq.sv
// Parametrised lamp-pattern sequencer: prescaled stepping of a WIDTH-bit pattern
// through hold/shift/rotate/bounce/LFSR/blink modes, with a bounce-direction FSM.
module light_dance_seq #(
    parameter int               WIDTH = 8,
    parameter int               DIV_W = 4,
    parameter logic [WIDTH-1:0] TAPS  = 8'hB8
) (
    input  logic                 clk,
    input  logic                 arst,
    light_dance_seq_if.slave     bus
);

    typedef enum logic [2:0] {
        M_HOLD   = 3'd0,
        M_SHL    = 3'd1,
        M_SHR    = 3'd2,
        M_ROL    = 3'd3,
        M_ROR    = 3'd4,
        M_BOUNCE = 3'd5,
        M_LFSR   = 3'd6,
        M_BLINK  = 3'd7
    } mode_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    localparam logic [WIDTH-1:0] LFSR_SEED = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [DIV_W-1:0] CNT_ONE   = {{(DIV_W-1){1'b0}}, 1'b1};

    function automatic logic f_parity(input logic [WIDTH-1:0] v);
        return ^v;
    endfunction

    function automatic logic [WIDTH-1:0] f_rol(input logic [WIDTH-1:0] v);
        return {v[WIDTH-2:0], v[WIDTH-1]};
    endfunction

    function automatic logic [WIDTH-1:0] f_ror(input logic [WIDTH-1:0] v);
        return {v[0], v[WIDTH-1:1]};
    endfunction

    logic [WIDTH-1:0] r_qdata;
    logic [DIV_W-1:0] r_cnt;
    logic             r_step;
    dir_e             r_dir;

    mode_e            w_mode;
    logic             w_tick;
    logic             w_q_nz;
    logic             w_bounce_left;
    logic             w_lfsr_fb;
    logic [WIDTH-1:0] w_next;
    dir_e             w_dir_nxt;

    assign w_mode = mode_e'(bus.mode);
    assign w_tick = bus.run && (r_cnt >= bus.div);
    assign w_q_nz = |r_qdata;

    // Bounce moves left while heading up unless the MSB is lit, and right while
    // heading down unless the LSB is lit; the edge lamp triggers the reversal.
    always_comb begin
        w_bounce_left = 1'b0;
        if (r_dir == DIR_UP) begin
            w_bounce_left = ~r_qdata[WIDTH-1];
        end else begin
            w_bounce_left = r_qdata[0];
        end
    end

    // LFSR feedback: tap parity XOR the serial input.
    always_comb begin
        w_lfsr_fb = f_parity(r_qdata & TAPS) ^ bus.din;
    end

    // Pattern to adopt on a tick, selected by the mode seen at that edge.
    always_comb begin
        w_next = r_qdata;
        case (w_mode)
            M_HOLD:   w_next = r_qdata;
            M_SHL:    w_next = {r_qdata[WIDTH-2:0], bus.din};
            M_SHR:    w_next = {bus.din, r_qdata[WIDTH-1:1]};
            M_ROL:    w_next = f_rol(r_qdata);
            M_ROR:    w_next = f_ror(r_qdata);
            M_BOUNCE: begin
                if (w_bounce_left) begin
                    w_next = f_rol(r_qdata);
                end else begin
                    w_next = f_ror(r_qdata);
                end
            end
            M_LFSR: begin
                if (!w_q_nz && !bus.din) begin
                    w_next = LFSR_SEED;
                end else begin
                    w_next = {r_qdata[WIDTH-2:0], w_lfsr_fb};
                end
            end
            M_BLINK:  w_next = ~r_qdata;
            default:  w_next = r_qdata;
        endcase
    end

    // Bounce-direction FSM next state; an all-dark bank never flips direction.
    always_comb begin
        w_dir_nxt = r_dir;
        if (bus.load) begin
            w_dir_nxt = DIR_UP;
        end else if (w_tick && (w_mode == M_BOUNCE) && w_q_nz) begin
            case (r_dir)
                DIR_UP: begin
                    if (r_qdata[WIDTH-1]) begin
                        w_dir_nxt = DIR_DOWN;
                    end else begin
                        w_dir_nxt = DIR_UP;
                    end
                end
                DIR_DOWN: begin
                    if (r_qdata[0]) begin
                        w_dir_nxt = DIR_UP;
                    end else begin
                        w_dir_nxt = DIR_DOWN;
                    end
                end
                default: w_dir_nxt = DIR_UP;
            endcase
        end else begin
            w_dir_nxt = r_dir;
        end
    end

    // Bounce-direction FSM state register.
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            r_dir <= DIR_UP;
        end else begin
            r_dir <= w_dir_nxt;
        end
    end

    // Prescaler, pattern and step pulse: load beats tick beats hold.
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            r_qdata <= {WIDTH{1'b0}};
            r_cnt   <= {DIV_W{1'b0}};
            r_step  <= 1'b0;
        end else if (bus.load) begin
            r_qdata <= bus.pdata;
            r_cnt   <= {DIV_W{1'b0}};
            r_step  <= 1'b0;
        end else if (w_tick) begin
            r_qdata <= w_next;
            r_cnt   <= {DIV_W{1'b0}};
            r_step  <= 1'b1;
        end else if (bus.run) begin
            r_qdata <= r_qdata;
            r_cnt   <= r_cnt + CNT_ONE;
            r_step  <= 1'b0;
        end else begin
            r_qdata <= r_qdata;
            r_cnt   <= r_cnt;
            r_step  <= 1'b0;
        end
    end

    assign bus.qdata = r_qdata;
    assign bus.step  = r_step;
    assign bus.dir   = r_dir;

endmodule

// File: tb/tb_light_dance_seq.sv
// Directed bench for light_dance_seq: arithmetic reference model checked every
// cycle, plus literal expectations from the worked examples.
module tb_light_dance_seq;

    localparam logic [7:0] TAPS = 8'hB8;

    logic clk  = 1'b0;
    logic arst = 1'b0;
    int   n_checks = 0;
    int   n_pass   = 0;
    bit   model_on = 1'b0;

    light_dance_seq_if #(.WIDTH(8), .DIV_W(4)) bus ();

    light_dance_seq #(.WIDTH(8), .DIV_W(4), .TAPS(TAPS)) dut (
        .clk  (clk),
        .arst (arst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Reference state
    logic [7:0] m_q;
    int         m_cnt;
    logic       m_step;
    logic       m_dir;

    function automatic logic [7:0] rot_l(input logic [7:0] q);
        return (q << 1) | (q >> 7);
    endfunction

    function automatic logic [7:0] rot_r(input logic [7:0] q);
        return (q >> 1) | (q << 7);
    endfunction

    always @(posedge clk or negedge arst) begin
        if (!arst) begin
            m_q <= 8'h00; m_cnt <= 0; m_step <= 1'b0; m_dir <= 1'b0;
        end else if (bus.load) begin
            m_q <= bus.pdata; m_cnt <= 0; m_step <= 1'b0; m_dir <= 1'b0;
        end else if (bus.run && m_cnt >= int'(bus.div)) begin
            m_cnt  <= 0;
            m_step <= 1'b1;
            case (bus.mode)
                3'd0: m_q <= m_q;
                3'd1: m_q <= (m_q << 1) | {7'd0, bus.din};
                3'd2: m_q <= (m_q >> 1) | {bus.din, 7'd0};
                3'd3: m_q <= rot_l(m_q);
                3'd4: m_q <= rot_r(m_q);
                3'd5: begin
                    if (m_q == 8'h00) m_q <= m_q;
                    else if (!m_dir && m_q >= 8'h80) begin m_dir <= 1'b1; m_q <= rot_r(m_q); end
                    else if (!m_dir) m_q <= rot_l(m_q);
                    else if (m_q % 2 == 1) begin m_dir <= 1'b0; m_q <= rot_l(m_q); end
                    else m_q <= rot_r(m_q);
                end
                3'd6: begin
                    if (m_q == 8'h00 && !bus.din) m_q <= 8'h01;
                    else m_q <= (m_q << 1) |
                                {7'd0, 1'(($countones(m_q & TAPS) % 2) ^ int'(bus.din))};
                end
                default: m_q <= ~m_q;
            endcase
        end else begin
            m_step <= 1'b0;
            if (bus.run) m_cnt <= m_cnt + 1;
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (model_on) begin
            n_checks++;
            if (bus.qdata === m_q && bus.step === m_step && bus.dir === m_dir) begin
                n_pass++;
            end else begin
                $display("FAIL model t=%0t got q=%h step=%b dir=%b want q=%h step=%b dir=%b",
                         $time, bus.qdata, bus.step, bus.dir, m_q, m_step, m_dir);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s got=%h want=%h", name, got, want);
    endtask

    task automatic cyc(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_load(input logic [7:0] p);
        bus.load = 1'b1; bus.pdata = p;
        cyc();
        bus.load = 1'b0;
    endtask

    logic [7:0] exp_b [15] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                               8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
    logic       exp_d [15] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                               1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [7:0] exp_l [5]  = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11};
    logic [7:0] exp_r [4]  = '{8'h86, 8'h0D, 8'h1A, 8'h34};

    initial begin
        bus.load = 1'b0; bus.pdata = 8'h00; bus.din = 1'b0;
        bus.mode = 3'd0; bus.div = 4'd0; bus.run = 1'b0;
        cyc(2);
        chk("reset_q", 32'(bus.qdata), 32'h00);
        chk("reset_step_dir", {30'd0, bus.step, bus.dir}, 32'd0);
        arst = 1'b1;
        model_on = 1'b1;

        // 1: ROL every cycle
        bus.mode = 3'd3; bus.div = 4'd0; bus.run = 1'b1;
        do_load(8'h43);
        chk("t1_load", {23'd0, bus.step, bus.qdata}, {23'd0, 1'b0, 8'h43});
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("t1_rol", {23'd0, bus.step, bus.qdata}, {23'd0, 1'b1, exp_r[i]});
        end

        // 2: SHL with din=1, period 4
        bus.mode = 3'd1; bus.din = 1'b1; bus.div = 4'd3;
        do_load(8'h00);
        for (int k = 0; k < 3; k++) begin
            for (int j = 0; j < 3; j++) begin
                cyc();
                chk("t2_nostep", 32'(bus.step), 32'd0);
            end
            cyc();
            chk("t2_shl", {23'd0, bus.step, bus.qdata}, {23'd0, 1'b1, 8'((8'h02 << k) - 8'h01)});
        end

        // 3: bounce sweep
        bus.mode = 3'd5; bus.div = 4'd0;
        do_load(8'h01);
        for (int i = 0; i < 15; i++) begin
            cyc();
            chk("t3_bounce", {23'd0, bus.dir, bus.qdata}, {23'd0, exp_d[i], exp_b[i]});
        end

        // 4: LFSR from lock-up state
        bus.mode = 3'd6; bus.din = 1'b0;
        do_load(8'h00);
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("t4_lfsr", 32'(bus.qdata), 32'(exp_l[i]));
        end
        for (int i = 0; i < 20; i++) begin
            cyc();
            chk("t4_nonzero", 32'(bus.qdata != 8'h00), 32'd1);
        end

        // 5: load wins over coincident tick, freeze, then blink
        bus.mode = 3'd3;
        do_load(8'hAA);
        chk("t5_load_tick", {23'd0, bus.step, bus.qdata}, {23'd0, 1'b0, 8'hAA});
        bus.run = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            chk("t5_hold", {23'd0, bus.step, bus.qdata}, {23'd0, 1'b0, 8'hAA});
        end
        bus.mode = 3'd7; bus.run = 1'b1;
        cyc(); chk("t5_blink0", 32'(bus.qdata), 32'h55);
        cyc(); chk("t5_blink1", 32'(bus.qdata), 32'hAA);
        cyc(); chk("t5_blink2", 32'(bus.qdata), 32'h55);

        // Lowering div below cnt ticks on the next edge
        bus.mode = 3'd0; bus.div = 4'd9;
        do_load(8'h3C);
        cyc(4);
        bus.div = 4'd1;
        cyc();
        chk("div_drop_tick", {23'd0, bus.step, bus.qdata}, {23'd0, 1'b1, 8'h3C});

        // Mixed modes and din, checked by the model only
        bus.div = 4'd1;
        do_load(8'h5A);
        for (int i = 0; i < 48; i++) begin
            bus.mode = 3'(i / 6);
            bus.din  = 1'(i % 3 == 0);
            bus.run  = 1'(i % 7 != 6);
            cyc();
        end

        // 6: async reset between edges, dir pre-set to 1 via bounce
        bus.mode = 3'd5; bus.div = 4'd0; bus.run = 1'b1;
        do_load(8'h80);
        cyc();
        chk("t6_dir_pre", 32'(bus.dir), 32'd1);
        bus.mode = 3'd3; bus.div = 4'd2;
        cyc(4);
        @(posedge clk);
        #2 arst = 1'b0;
        #1;
        chk("t6_async", {22'd0, bus.step, bus.dir, bus.qdata}, 32'd0);
        cyc();
        arst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cyc();
            chk("t6_nostep", 32'(bus.step), 32'd0);
        end
        cyc();
        chk("t6_first_step", 32'(bus.step), 32'd1);
        cyc(3);

        model_on = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
